// File: rtl/bus_response_collector_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : bus_response_collector_pkg                            |
// | Purpose  : Shared encodings for the data-bus response collector: |
// |            target one-hot codes, FSM states, default error data. |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package bus_response_collector_pkg;

  // One-hot target codes, bit order {dma, pctrl, mem}
  localparam logic [2:0] TGT_NONE  = 3'b000;
  localparam logic [2:0] TGT_MEM   = 3'b001;
  localparam logic [2:0] TGT_PCTRL = 3'b010;
  localparam logic [2:0] TGT_DMA   = 3'b100;

  // Read data returned when an access ends in a bus error
  localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEADBEEF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // True when exactly one decoder select is asserted
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == TGT_MEM) || (v == TGT_PCTRL) || (v == TGT_DMA);
  endfunction

  // Saturating 8-bit increment for the error counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : bus_timeout_counter                                   |
// | Purpose  : Counts WAIT cycles of an outstanding bus access and   |
// |            flags the last permitted cycle (TIMEOUT_CYCLES-1).    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Width holds values 0..TIMEOUT_CYCLES-1; one bit minimum for TIMEOUT_CYCLES=2
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Clear on a new acceptance, otherwise advance on every unacknowledged WAIT cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/bus_response_collector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : bus_response_collector                                |
// | Purpose  : Data-bus return path. Latches the decoder-selected    |
// |            target at acceptance, waits for its acknowledge and   |
// |            returns a one-cycle response; times out or rejects    |
// |            bad selects with a bus-error response.                |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module bus_response_collector
  import bus_response_collector_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 16,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = DATA_WIDTH'(DEFAULT_ERROR_DATA)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic                  sel_peripheral_mem,
  input  logic                  sel_peripheral_pctrl,
  input  logic                  sel_peripheral_dma,
  input  logic                  mem_ack,
  input  logic                  pctrl_ack,
  input  logic                  dma_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [DATA_WIDTH-1:0] pctrl_rdata,
  input  logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  busy,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [7:0]            err_count
);

  state_t                state;
  logic [2:0]            target;
  logic                  is_write;

  logic [2:0]            sel_vec;
  logic [2:0]            ack_vec;
  logic                  ack_hit;
  logic [DATA_WIDTH-1:0] ack_rdata;
  logic                  accept;
  logic                  tmo_enable;
  logic                  tmo_expired;

  assign sel_vec = {sel_peripheral_dma, sel_peripheral_pctrl, sel_peripheral_mem};
  assign ack_vec = {dma_ack, pctrl_ack, mem_ack};

  // Only the captured target's strobe counts; others are masked off
  assign ack_hit    = |(target & ack_vec);
  assign accept     = (state == ST_IDLE) && req_valid;
  assign tmo_enable = (state == ST_WAIT) && !ack_hit;

  // Read data of the captured target
  always_comb begin
    ack_rdata = '0;
    case (target)
      TGT_MEM:   ack_rdata = mem_rdata;
      TGT_PCTRL: ack_rdata = pctrl_rdata;
      TGT_DMA:   ack_rdata = dma_rdata;
      default:   ack_rdata = '0;
    endcase
  end

  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // Transaction FSM with registered response outputs; responses default to a zero pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      target     <= TGT_NONE;
      is_write   <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      err_count  <= 8'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            target   <= sel_vec;
            is_write <= req_write;
            if (is_onehot3(sel_vec)) begin
              state <= ST_WAIT;
              busy  <= 1'b1;
            end else begin
              // No or ambiguous target: reject without ever stalling the core
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= req_write ? '0 : ERROR_DATA;
              err_count  <= sat_inc8(err_count);
            end
          end
        end
        ST_WAIT: begin
          // An ack on the final permitted cycle takes priority over the timeout
          if (ack_hit) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            target     <= TGT_NONE;
            resp_valid <= 1'b1;
            resp_rdata <= is_write ? '0 : ack_rdata;
          end else if (tmo_expired) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            target     <= TGT_NONE;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= is_write ? '0 : ERROR_DATA;
            err_count  <= sat_inc8(err_count);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
